// File: rtl/updown_counter_if.sv
// rtl/updown_counter_if.sv - control/status bundle for one updown_counter stage
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;

    // driver side: whoever steers the counter and observes its status
    modport master (
        output en, up, load, load_val, clr_ovf,
        input  out, tc, ovf
    );

    // counter side
    modport slave (
        input  en, up, load, load_val, clr_ovf,
        output out, tc, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised synchronous up/down modulo counter with load, tc and sticky wrap flag
module updown_counter #(
    parameter int              WIDTH      = 4,
    parameter longint unsigned MODULO     = 16,
    parameter bit              INVERT_OUT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    updown_counter_if.slave    bus
);
    // largest legal count; equals all-ones when MODULO is a full power of two,
    // which makes both the wrap compare and the load clamp degenerate naturally
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_step;

    // terminal-count decode and next-step value, shared by tc, ovf and the count register
    always_comb begin
        w_at_max       = (r_cnt == L_MAX);
        w_at_zero      = (r_cnt == '0);
        w_wrap         = bus.en & (bus.up ? w_at_max : w_at_zero) & ~bus.load & ~rst;
        w_load_clamped = (bus.load_val > L_MAX) ? L_MAX : bus.load_val;
        if (bus.up) begin
            w_step = w_at_max ? '0 : r_cnt + WIDTH'(1);
        end else begin
            w_step = w_at_zero ? L_MAX : r_cnt - WIDTH'(1);
        end
    end

    // count register: reset beats load, load beats step, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (bus.load) begin
            r_cnt <= w_load_clamped;
        end else if (bus.en) begin
            r_cnt <= w_step;
        end
    end

    // sticky wrap flag: a wrap on the same edge as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.out = INVERT_OUT ? ~r_cnt : r_cnt;
    assign bus.tc  = w_wrap;
    assign bus.ovf = r_ovf;
endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down modulo counter, the successor to the team's 4-bit ripple counter. It replaces the per-bit flop clock chaining with a single-clock design that adds:
- configurable width and modulus, and direction control;
- parallel load;
- a cascade-ready terminal-count output and a sticky wrap flag.

It is used wherever a free-running or loadable event/divider counter is needed. Wider counts are built by chaining instances through `tc` → `en`.

## Interface
Parameters:
- `WIDTH`, 4: count register width in bits; 1..32.
- `MODULO`, 16: count sequence length; count runs 0..MODULO-1; legal range 2..2^WIDTH.
- `INVERT_OUT`, 0: 1 drives `out` with the bitwise complement of the count (legacy active-low display/readout); 0 drives the true count.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: count enable; one step per enabled edge.
- `up`, in, 1: direction; 1 = increment, 0 = decrement.
- `load`, in, 1: parallel load strobe.
- `load_val`, in, WIDTH: value captured on `load`.
- `clr_ovf`, in, 1: clears sticky `ovf`.
- `out`, out, WIDTH: count, or ~count when INVERT_OUT=1.
- `tc`, out, 1: terminal count, combinational; high when the next enabled edge wraps.
- `ovf`, out, 1: sticky wrap flag, registered.

## Operation
- Internal register `cnt[WIDTH-1:0]`, always within 0..MODULO-1.
- Priority per edge: `rst` > `load` > `en`. Otherwise `cnt` holds.
- `rst`=1 sets `cnt`=0 and `ovf`=0.
  - `out`=0 when INVERT_OUT=0; `out`=all-ones when INVERT_OUT=1.
  - Reset asserted mid-count is effective at the next edge regardless of `load`/`en`.
- `load`=1:
  - `cnt` ← `load_val` if `load_val` ≤ MODULO-1, else `cnt` ← MODULO-1 (clamp).
  - A load never sets `ovf` and ignores `en`/`up`.
- `en`=1, `up`=1: `cnt` ← (`cnt`==MODULO-1) ? 0 : `cnt`+1.
- `en`=1, `up`=0: `cnt` ← (`cnt`==0) ? MODULO-1 : `cnt`-1.
- `tc` = `en` & (`up` ? `cnt`==MODULO-1 : `cnt`==0) & ~`load` & ~`rst`. It is purely combinational from inputs and `cnt`.
- `ovf` is set on any edge where a wrap occurs (`tc`=1). It is cleared on an edge with `clr_ovf`=1 and no wrap.
  - Simultaneous wrap and `clr_ovf`: set wins, `ovf`=1.
- Direction change takes effect on the same edge `up` is sampled. No pipeline, no hysteresis.
- MODULO=2^WIDTH: wrap is natural binary roll-over; the clamp is never active.
- Cascading: the low stage's `tc` drives the high stage's `en`, with all stages sharing `clk`, `rst` and `up`. This yields a synchronous WIDTH×N counter with no ripple delay.

## Timing
- Latency: `out` reflects a load or step one edge after the controlling inputs are sampled. Zero-cycle combinational path from `cnt` to `out`.
- `tc` is valid in the same cycle as the `cnt`/`en`/`up` values that cause it. It is a one-cycle pulse per wrap under continuous `en`.
- `ovf` rises one edge after the wrapping edge's inputs are sampled, i.e. coincident with `cnt` showing the wrapped value.
- All outputs are defined from the first edge with `rst`=1. Outputs before the first reset edge are don't-care.
- No multicycle paths. `load_val` and `clr_ovf` need standard setup/hold to `clk` only.

## Test plan
- Reset/default: WIDTH=4, MODULO=16. Hold `rst`=1 for 2 edges, then `en`=1, `up`=1 for 17 edges → `out` goes 0,1,…,15,0,1; `tc`=1 only while `cnt`=15; `ovf`=1 from the edge that shows 0.
- Non-power-of-two down count: MODULO=10. Load 3, then `en`=1, `up`=0 for 5 edges → `cnt` 3,2,1,0,9,8; `tc` high only at `cnt`=0; `ovf` set.
- Load clamp and priority: MODULO=10, `load_val`=13 with `load`=1 and `en`=1 → `cnt`=9, `ovf` unchanged. Then `rst`=1 with `load`=1 → `cnt`=0.
- Sticky flag race: `cnt`=MODULO-1, `en`=1, `up`=1, `clr_ovf`=1 on the same edge → `ovf`=1. Next edge with `clr_ovf`=1 and no wrap → `ovf`=0.
- INVERT_OUT=1, WIDTH=4: after reset `out`=4'hF; after 3 up-steps `out`=4'hC.
- Cascade: two WIDTH=4 instances chained via `tc`→`en`, up-count 300 edges from reset → concatenated count = 300 mod 256 = 44; the high stage changes only on edges where the low stage wraps.
